din_debounce: RTL and testbench

Conditions one raw digital input pin before edge-sensitive consumers such as `din_toggle`. The block does three things:
- synchronises the pin into the `clk` domain;
- rejects bounce shorter than a programmable qualification window;
- emits a clean level plus single-cycle rise/fall strobes.

It sits directly upstream of `din_toggle` and of the plain DIN register path. It also reports a saturating bounce counter for diagnostics.

---
 rtl/din_debounce_pkg.sv | 17 +
 rtl/din_sync.sv | 28 ++
 rtl/din_debounce.sv | 111 +++++++++++
 tb/tb_din_debounce.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/din_debounce_pkg.sv
// din_debounce shared types: FSM state, diagnostic width,
// and the width function for the qualification counter.
package din_debounce_pkg;

  typedef enum logic {
    STABLE,
    QUAL
  } state_t;

  localparam int BOUNCE_CNT_W = 8;

  // Holds 0..n without wrapping; at least one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/din_sync.sv
// Generic N-stage flop synchroniser, sync active-low reset.
// Ports: clk, rst_n, d (async in), q (last stage out).
module din_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/din_debounce.sv
// Debounces one raw pin: sync, qualify, level + rise/fall strobes.
// Ports: clk, rst_n, din, bounce_clr -> dout, rise, fall, bounce_cnt.
module din_debounce
  import din_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit INIT            = 1'b0,
  parameter bit INVERT          = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  output logic                    dout,
  output logic                    rise,
  output logic                    fall,
  output logic [BOUNCE_CNT_W-1:0] bounce_cnt,
  input  logic                    bounce_clr
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BOUNCE_CNT_W-1:0] BMAX = '1;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_range
    $error("din_debounce: DEBOUNCE_CYCLES out of range 1..2^20");
  end

  logic din_s;

  din_sync #(
    .STAGES (2),
    .RST_VAL(INIT)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (din ^ INVERT),
    .q    (din_s)
  );

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    dout_n, rise_n, fall_n;
  logic [BOUNCE_CNT_W-1:0] bcnt_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= STABLE;
      cnt        <= '0;
      dout       <= INIT;
      rise       <= 1'b0;
      fall       <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      rise       <= rise_n;
      fall       <= fall_n;
      bounce_cnt <= bcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    bcnt_n  = bounce_cnt;
    unique case (state)
      STABLE: begin
        if (din_s == dout) begin
          cnt_n = '0;
        end else if (DEBOUNCE_CYCLES == 1) begin
          // single-sample window: accept without entering QUAL
          dout_n = din_s;
          rise_n = din_s;
          fall_n = !din_s;
        end else begin
          state_n = QUAL;
          cnt_n   = CW'(1);
        end
      end
      QUAL: begin
        if (din_s == dout) begin
          state_n = STABLE;
          cnt_n   = '0;
          if (bounce_cnt != BMAX) begin
            bcnt_n = bounce_cnt + 1'b1;
          end
        end else if (cnt == LAST) begin
          state_n = STABLE;
          cnt_n   = '0;
          dout_n  = din_s;
          rise_n  = din_s;
          fall_n  = !din_s;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = STABLE;
        cnt_n   = '0;
      end
    endcase
    if (bounce_clr) begin
      bcnt_n = '0;
    end
  end

endmodule

// File: tb/tb_din_debounce.sv
// Self-checking bench for din_debounce: vector table plus
// directed sequences for reset, saturation, INVERT and toggling.
module tb_din_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic d0 = 0, r0 = 0, c0 = 0, o0, ri0, fa0;
  logic d1 = 1, r1 = 0, c1 = 0, o1, ri1, fa1;
  logic d2 = 0, r2 = 0, c2 = 0, o2, ri2, fa2;
  logic d3 = 1, r3 = 0, c3 = 0, o3, ri3, fa3;
  logic [7:0] bc0, bc1, bc2, bc3;

  din_debounce #(.DEBOUNCE_CYCLES(4), .INIT(1'b0), .INVERT(1'b0)) u0 (
    .clk(clk), .rst_n(r0), .din(d0), .dout(o0), .rise(ri0),
    .fall(fa0), .bounce_cnt(bc0), .bounce_clr(c0));
  din_debounce #(.DEBOUNCE_CYCLES(4), .INIT(1'b1), .INVERT(1'b0)) u1 (
    .clk(clk), .rst_n(r1), .din(d1), .dout(o1), .rise(ri1),
    .fall(fa1), .bounce_cnt(bc1), .bounce_clr(c1));
  din_debounce #(.DEBOUNCE_CYCLES(8), .INIT(1'b0), .INVERT(1'b0)) u2 (
    .clk(clk), .rst_n(r2), .din(d2), .dout(o2), .rise(ri2),
    .fall(fa2), .bounce_cnt(bc2), .bounce_clr(c2));
  din_debounce #(.DEBOUNCE_CYCLES(1), .INIT(1'b0), .INVERT(1'b1)) u3 (
    .clk(clk), .rst_n(r3), .din(d3), .dout(o3), .rise(ri3),
    .fall(fa3), .bounce_cnt(bc3), .bounce_clr(c3));

  // downstream toggle consumer model fed by u3.rise
  logic tog;
  int   tog_n;
  always @(posedge clk) begin
    if (!r3) begin
      tog   <= 1'b0;
      tog_n <= 0;
    end else if (ri3) begin
      tog   <= ~tog;
      tog_n <= tog_n + 1;
    end
  end

  typedef struct {
    logic       din;
    logic       rst_n;
    logic       clr;
    logic       dout;
    logic       rise;
    logic       fall;
    logic [7:0] bcnt;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic din, input logic rn,
                              input logic clr, input logic dout,
                              input logic rise, input logic fall,
                              input int bcnt);
    vec_t v;
    v.din   = din;
    v.rst_n = rn;
    v.clr   = clr;
    v.dout  = dout;
    v.rise  = rise;
    v.fall  = fall;
    v.bcnt  = 8'(bcnt);
    tv.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one u0 pulse: `hi` cycles high then low to 8 cycles total
  task automatic pulse0(input int hi, input int clr_at);
    for (int i = 0; i < 8; i++) begin
      d0 = (i < hi);
      c0 = (i == clr_at);
      tick();
    end
    c0 = 1'b0;
  endtask

  initial begin
    // reset, INIT=0, then release
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    // clean 0->1 step: dout/rise at edge 5
    for (int i = 0; i < 7; i++) add(1, 1, 0, 1'(i >= 5), 1'(i == 5), 0, 0);
    // clean 1->0 step: fall at edge 5
    for (int i = 0; i < 7; i++) add(0, 1, 0, 1'(i < 5), 0, 1'(i == 5), 0);
    // five 3-cycle pulses: rejected, bcnt bumps at edge 5
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 8; i++)
        add(1'(i < 3), 1, 0, 0, 0, 0, (i >= 5) ? p + 1 : p);
    // 4-cycle pulse: accepted, fall 5 edges after its end
    for (int i = 0; i < 14; i++)
      add(1'(i < 4), 1, 0, 1'(i >= 5 && i < 9), 1'(i == 5),
          1'(i == 9), 5);

    for (int i = 0; i < tv.size(); i++) begin
      d0 = tv[i].din;
      r0 = tv[i].rst_n;
      c0 = tv[i].clr;
      tick();
      chk($sformatf("u0_vec%0d", i),
          int'({o0, ri0, fa0, bc0}),
          int'({tv[i].dout, tv[i].rise, tv[i].fall, tv[i].bcnt}));
    end

    // saturation: 300 more rejected pulses on top of 5
    for (int p = 0; p < 300; p++) pulse0(3, -1);
    chk("sat_bcnt", int'(bc0), 255);
    chk("sat_dout", int'(o0), 0);
    // clear coinciding with a bounce (bounce lands at edge 5)
    pulse0(3, 5);
    chk("clr_vs_bounce", int'(bc0), 0);
    pulse0(3, -1);
    chk("bcnt_after_clr", int'(bc0), 1);
    c0 = 1'b1;
    tick();
    c0 = 1'b0;
    chk("plain_clr", int'(bc0), 0);

    // INIT=1 reset, din held high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("u1_rst%0d", i), int'({o1, ri1, fa1, bc1}), 11'h400);
    end
    r1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("u1_rel%0d", i), int'({o1, ri1, fa1, bc1}), 11'h400);
    end

    // N=8: reset while cnt=5, new window counted from release
    r2 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    d2 = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      chk($sformatf("u2_e%0d", e), int'({o2, ri2, fa2}), 0);
    end
    r2 = 1'b0;
    tick();
    chk("u2_e7_rst", int'({o2, ri2, fa2, bc2}), 0);
    r2 = 1'b1;
    for (int e = 8; e < 21; e++) begin
      tick();
      chk($sformatf("u2_e%0d", e), int'({o2, ri2, fa2}),
          int'({1'(e >= 17), 1'(e == 17), 1'b0}));
    end
    chk("u2_bcnt", int'(bc2), 0);

    // INVERT=1, N=1: pin low -> rise at edge 2
    tick();
    r3 = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    chk("u3_idle", int'({o3, ri3, fa3}), 0);
    for (int s = 0; s < 3; s++) begin
      d3 = 1'(s % 2);
      for (int e = 0; e < 4; e++) begin
        tick();
        if (s % 2 == 0)
          chk($sformatf("u3_s%0d_e%0d", s, e), int'({o3, ri3, fa3}),
              int'({1'(e >= 2), 1'(e == 2), 1'b0}));
        else
          chk($sformatf("u3_s%0d_e%0d", s, e), int'({o3, ri3, fa3}),
              int'({1'(e < 2), 1'b0, 1'(e == 2)}));
      end
    end
    tick();
    chk("tog_count", tog_n, 2);
    chk("tog_level", int'(tog), 0);
    chk("u3_bcnt", int'(bc3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
